// File: rtl/gray_binarize_pkg.sv
// Shared sizes and FSM encodings for the gray-to-binary BMP stage.
package gray_binarize_pkg;

  localparam int BYTE_WIDTH      = 8;
  localparam int ADDR_WIDTH      = 20;
  localparam int BMP_HEADER_SIZE = 54;
  localparam int BMP_TOTAL_SIZE  = 54 + 3 * 640 * 480;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_HDR_RD = 3'd1;
  localparam logic [2:0] S_HDR_WR = 3'd2;
  localparam logic [2:0] S_PIX_RD = 3'd3;
  localparam logic [2:0] S_PIX_W0 = 3'd4;
  localparam logic [2:0] S_PIX_W1 = 3'd5;
  localparam logic [2:0] S_PIX_W2 = 3'd6;
  localparam logic [2:0] S_DONE   = 3'd7;

endpackage

// File: rtl/gray_binarize_bin_threshold.sv
// Combinational gray-level threshold: inclusive unsigned compare, 0x00/0xFF out.
module bin_threshold #(
  parameter int BYTE_WIDTH = 8
) (
  input  logic [BYTE_WIDTH-1:0] gray,
  input  logic [BYTE_WIDTH-1:0] thr,
  output logic [BYTE_WIDTH-1:0] bin
);

  always_comb begin
    bin = (gray >= thr) ? '1 : '0;
  end

endmodule

// File: rtl/gray_binarize.sv
// Copies the BMP header from the gray RAM and writes a thresholded B/G/R image.
module gray_binarize
  import gray_binarize_pkg::*;
#(
  parameter int BYTE_WIDTH = gray_binarize_pkg::BYTE_WIDTH,
  parameter int ADDR_WIDTH = gray_binarize_pkg::ADDR_WIDTH,
  parameter int HDR_SIZE   = BMP_HEADER_SIZE,
  parameter int TOTAL_SIZE = BMP_TOTAL_SIZE
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [BYTE_WIDTH-1:0] threshold,
  input  logic [BYTE_WIDTH-1:0] RAM_Q,
  output logic                  RAM_ren,
  output logic [ADDR_WIDTH-1:0] RAM_addr,
  output logic                  OUT_wen,
  output logic [ADDR_WIDTH-1:0] OUT_addr,
  output logic [BYTE_WIDTH-1:0] OUT_D,
  output logic                  bin_done
);

  localparam logic [ADDR_WIDTH-1:0] HDR_LAST = ADDR_WIDTH'(HDR_SIZE - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST     = ADDR_WIDTH'(TOTAL_SIZE - 1);

  logic [2:0]            state;
  logic [BYTE_WIDTH-1:0] thr_q;
  logic [BYTE_WIDTH-1:0] bin_q;
  logic [BYTE_WIDTH-1:0] pix_bin;
  logic                  wr_last;

  bin_threshold #(.BYTE_WIDTH(BYTE_WIDTH)) u_thr (
    .gray (RAM_Q),
    .thr  (thr_q),
    .bin  (pix_bin)
  );

  always_comb begin
    RAM_ren = (state == S_HDR_RD) || (state == S_PIX_RD);
    OUT_wen = (state == S_HDR_WR) || (state == S_PIX_W0) ||
              (state == S_PIX_W1) || (state == S_PIX_W2);
    wr_last = OUT_wen && (OUT_addr == LAST);
    case (state)
      S_HDR_WR:           OUT_D = RAM_Q;
      S_PIX_W0:           OUT_D = pix_bin;
      S_PIX_W1, S_PIX_W2: OUT_D = bin_q;
      default:            OUT_D = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      RAM_addr <= '0;
      OUT_addr <= '0;
      thr_q    <= '0;
      bin_q    <= '0;
      bin_done <= 1'b0;
    end else begin
      if (OUT_wen) begin
        OUT_addr <= OUT_addr + 1'b1;
      end
      // The last-byte check overrides the normal successor in every write
      // state, so a partial final pixel is simply cut short.
      if (wr_last) begin
        bin_done <= 1'b1;
        state    <= S_DONE;
      end
      case (state)
        S_IDLE: begin
          if (in_valid && !bin_done) begin
            thr_q <= threshold;
            state <= S_HDR_RD;
          end
        end
        S_HDR_RD: state <= S_HDR_WR;
        S_HDR_WR: begin
          RAM_addr <= RAM_addr + 1'b1;
          if (!wr_last) begin
            state <= (OUT_addr == HDR_LAST) ? S_PIX_RD : S_HDR_RD;
          end
        end
        S_PIX_RD: state <= S_PIX_W0;
        S_PIX_W0: begin
          bin_q <= pix_bin;
          if (!wr_last) state <= S_PIX_W1;
        end
        S_PIX_W1: begin
          if (!wr_last) state <= S_PIX_W2;
        end
        S_PIX_W2: begin
          RAM_addr <= RAM_addr + ADDR_WIDTH'(3);
          if (!wr_last) state <= S_PIX_RD;
        end
        S_DONE:   state <= S_DONE;
        default:  state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gray_binarize.sv
// Scoreboard bench for gray_binarize with a 4-byte header: full and truncated images.
module tb_gray_binarize;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid_a = 1'b0;
  logic        in_valid_b = 1'b0;
  logic [7:0]  threshold = 8'h00;

  logic [7:0]  a_q, b_q;
  logic        a_ren, b_ren, a_wen, b_wen, a_done, b_done;
  logic [19:0] a_raddr, b_raddr, a_oaddr, b_oaddr;
  logic [7:0]  a_d, b_d;

  logic [7:0]  ram_a [16];
  logic [7:0]  ram_b [16];

  typedef struct {
    int         addr;
    logic [7:0] data;
  } wr_t;

  wr_t qa[$];
  wr_t qb[$];

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [103:0] EXP1 = {8'h42, 8'h4D, 8'h11, 8'h22, 8'h00, 8'h00, 8'h00,
                                   8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00};
  localparam logic [103:0] EXP2 = {8'h42, 8'h4D, 8'h11, 8'h22, 8'hFF, 8'hFF, 8'hFF,
                                   8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
  localparam logic [103:0] EXP3 = {8'h42, 8'h4D, 8'h11, 8'h22, 8'h00, 8'h00, 8'h00,
                                   8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00};

  always #5 clk = ~clk;

  gray_binarize #(.BYTE_WIDTH(8), .ADDR_WIDTH(20), .HDR_SIZE(4), .TOTAL_SIZE(13)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a), .threshold(threshold),
    .RAM_Q(a_q), .RAM_ren(a_ren), .RAM_addr(a_raddr), .OUT_wen(a_wen),
    .OUT_addr(a_oaddr), .OUT_D(a_d), .bin_done(a_done)
  );

  gray_binarize #(.BYTE_WIDTH(8), .ADDR_WIDTH(20), .HDR_SIZE(4), .TOTAL_SIZE(11)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .threshold(threshold),
    .RAM_Q(b_q), .RAM_ren(b_ren), .RAM_addr(b_raddr), .OUT_wen(b_wen),
    .OUT_addr(b_oaddr), .OUT_D(b_d), .bin_done(b_done)
  );

  // Synchronous source RAMs: data one cycle after the read enable.
  always @(posedge clk) begin
    if (a_ren) a_q <= ram_a[a_raddr[3:0]];
    if (b_ren) b_q <= ram_b[b_raddr[3:0]];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : mon_a
    wr_t e;
    if (a_wen === 1'b1) begin
      if (qa.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL a_unexpected_write: addr %0d data %02h, expected no write", a_oaddr, a_d);
      end else begin
        e = qa.pop_front();
        check("a_wr_addr", 32'(a_oaddr), 32'(e.addr));
        check("a_wr_data", 32'(a_d), 32'(e.data));
      end
    end
  end

  always @(negedge clk) begin : mon_b
    wr_t e;
    if (b_wen === 1'b1) begin
      if (qb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL b_unexpected_write: addr %0d data %02h, expected no write", b_oaddr, b_d);
      end else begin
        e = qb.pop_front();
        check("b_wr_addr", 32'(b_oaddr), 32'(e.addr));
        check("b_wr_data", 32'(b_d), 32'(e.data));
      end
    end
  end

  task automatic load(input bit to_b, input logic [7:0] p0, input logic [7:0] p1, input logic [7:0] p2);
    logic [7:0] img [13];
    img = '{8'h42, 8'h4D, 8'h11, 8'h22, p0, p0, p0, p1, p1, p1, p2, p2, p2};
    for (int i = 0; i < 16; i++) begin
      if (to_b) ram_b[i] = (i < 13) ? img[i] : 8'h00;
      else      ram_a[i] = (i < 13) ? img[i] : 8'h00;
    end
  endtask

  task automatic push_exp(input bit to_b, input logic [103:0] exp, input int n);
    wr_t e;
    for (int i = 0; i < n; i++) begin
      e.addr = i;
      e.data = exp[103 - 8*i -: 8];
      if (to_b) qb.push_back(e);
      else      qa.push_back(e);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic pulse_a();
    @(negedge clk);
    in_valid_a = 1'b1;
    @(negedge clk);
    in_valid_a = 1'b0;
  endtask

  // Runs one image on dut_a; optionally pokes threshold and in_valid mid-image.
  task automatic run_a(input string tag, input logic [103:0] exp, input logic [7:0] thr, input bit poke);
    int cnt;
    bit seen;
    cnt = 0;
    seen = 0;
    push_exp(1'b0, exp, 13);
    threshold = thr;
    pulse_a();
    for (int c = 0; c < 200; c++) begin
      if (a_ren || a_wen) cnt++;
      if (a_done) begin
        seen = 1;
        break;
      end
      if (poke && cnt == 12) begin
        threshold  = 8'h00;
        in_valid_a = 1'b1;
      end else begin
        in_valid_a = 1'b0;
      end
      @(negedge clk);
    end
    in_valid_a = 1'b0;
    #1;
    check({tag, "_done"}, 32'(seen), 32'd1);
    check({tag, "_cycles"}, 32'(cnt), 32'd20);
    check({tag, "_queue_empty"}, 32'(qa.size()), 32'd0);
    qa.delete();
  endtask

  initial begin : stim
    int  act;
    int  cnt;
    bit  found;

    repeat (2) @(negedge clk);
    check("rst_ren", 32'(a_ren), 32'd0);
    check("rst_wen", 32'(a_wen), 32'd0);
    check("rst_outd", 32'(a_d), 32'd0);
    check("rst_raddr", 32'(a_raddr), 32'd0);
    check("rst_oaddr", 32'(a_oaddr), 32'd0);
    check("rst_done", 32'(a_done), 32'd0);
    rst_n = 1'b1;

    // Main image, with a threshold change and start pulse in the middle.
    load(1'b0, 8'h10, 8'h80, 8'h7F);
    run_a("img1", EXP1, 8'h80, 1'b1);

    // Start after completion must be ignored.
    threshold = 8'hFF;
    pulse_a();
    act = 0;
    repeat (8) begin
      @(negedge clk);
      if (a_ren || a_wen) act++;
    end
    check("post_done_activity", 32'(act), 32'd0);
    check("post_done_sticky", 32'(a_done), 32'd1);

    // Threshold extremes.
    do_reset();
    load(1'b0, 8'h00, 8'hFF, 8'h80);
    run_a("thr00", EXP2, 8'h00, 1'b0);
    do_reset();
    run_a("thrFF", EXP3, 8'hFF, 1'b0);

    // Asynchronous reset during the second write of the first pixel.
    do_reset();
    load(1'b0, 8'h10, 8'h80, 8'h7F);
    push_exp(1'b0, EXP1, 13);
    threshold = 8'h80;
    pulse_a();
    found = 0;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk);
      #1;
      if (a_wen && a_oaddr == 20'd5) begin
        found = 1;
        break;
      end
    end
    check("w1_reached", 32'(found), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_ren", 32'(a_ren), 32'd0);
    check("arst_wen", 32'(a_wen), 32'd0);
    check("arst_outd", 32'(a_d), 32'd0);
    check("arst_raddr", 32'(a_raddr), 32'd0);
    check("arst_oaddr", 32'(a_oaddr), 32'd0);
    check("arst_done", 32'(a_done), 32'd0);
    qa.delete();
    @(negedge clk);
    rst_n = 1'b1;
    run_a("restart", EXP1, 8'h80, 1'b0);

    // Truncated final pixel on the 11-byte image.
    load(1'b1, 8'h10, 8'h80, 8'h7F);
    push_exp(1'b1, EXP1, 11);
    threshold = 8'h80;
    @(negedge clk);
    in_valid_b = 1'b1;
    @(negedge clk);
    in_valid_b = 1'b0;
    cnt = 0;
    found = 0;
    for (int c = 0; c < 200; c++) begin
      if (b_ren || b_wen) cnt++;
      if (b_done) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    repeat (5) @(negedge clk);
    #1;
    check("trunc_done", 32'(found), 32'd1);
    check("trunc_cycles", 32'(cnt), 32'd18);
    check("trunc_queue_empty", 32'(qb.size()), 32'd0);
    check("trunc_done_sticky", 32'(b_done), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gray_binarize.md
Name: gray_binarize

Overview:
- Reads the gray BMP image that the gray-conversion stage writes into the shared RAM, byte by byte.
- Copies the BMP header unchanged to an output RAM.
- Thresholds each gray pixel and writes a B/G/R triple of 0x00 or 0xFF, giving a BMP-format binary image.
- Sits directly downstream of the gray stage; its start (in_valid) is driven from that stage's done flag.

Parameters:
- BYTE_WIDTH, 8, data byte width.
- ADDR_WIDTH, 20, RAM address width.
- HDR_SIZE, 54, BMP header length in bytes.
- TOTAL_SIZE, 54+3*W*H, total image bytes (header plus pixel data).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  start pulse; sampled only in IDLE.
- threshold  in  BYTE_WIDTH  binarization level; latched on accepted start.
- RAM_Q  in  BYTE_WIDTH  source gray RAM read data; synchronous, valid 1 cycle after RAM_ren.
- RAM_ren  out  1  source RAM read enable.
- RAM_addr  out  ADDR_WIDTH  source RAM read address.
- OUT_wen  out  1  output RAM write enable.
- OUT_addr  out  ADDR_WIDTH  output RAM write address.
- OUT_D  out  BYTE_WIDTH  output RAM write data.
- bin_done  out  1  high once all TOTAL_SIZE bytes are written; sticky until reset.

Behaviour:
- Reset (async, rst_n low): all outputs reset as follows.
  - state=IDLE.
  - RAM_addr=0, OUT_addr=0, thr_q=0, bin_q=0.
  - bin_done=0, RAM_ren=0, OUT_wen=0, OUT_D=0.
  - Reset mid-operation aborts immediately with no partial-state retention.
- Enables RAM_ren and OUT_wen are Moore-decoded from state and forced 0 in IDLE/DONE. Addresses are registers.
- States and transitions:
  - IDLE: on in_valid and !bin_done, latch threshold into thr_q, go to HDR_RD. Otherwise stay.
  - HDR_RD: RAM_ren=1 at RAM_addr. Next state is HDR_WR.
  - HDR_WR: OUT_wen=1, OUT_D=RAM_Q. RAM_addr and OUT_addr both increment. Next state is PIX_RD if OUT_addr==HDR_SIZE-1, else HDR_RD. Header costs 2 cycles/byte.
  - PIX_RD: RAM_ren=1 at RAM_addr, which is the B byte of the pixel. Next state is PIX_W0.
  - PIX_W0: bin_q <= (RAM_Q >= thr_q) ? 0xFF : 0x00, and OUT_D drives that same value combinationally. OUT_wen=1. Next state is PIX_W1.
  - PIX_W1: OUT_D=bin_q, OUT_wen=1. Next state is PIX_W2.
  - PIX_W2: OUT_D=bin_q, OUT_wen=1. RAM_addr += 3. Next state is PIX_RD. Pixel costs 4 cycles.
  - DONE: enables 0. Stays until reset; in_valid is ignored.
- OUT_addr increments on every write cycle.
- Any write with OUT_addr==TOTAL_SIZE-1 sets bin_done on the next edge and goes to DONE. This applies in any write state, including HDR_WR when TOTAL_SIZE==HDR_SIZE.
- A trailing partial triple is truncated, so no write is ever made at address >= TOTAL_SIZE.
- G/R source bytes are never read; the upstream stage guarantees B=G=R.
- Comparison is unsigned 8-bit, inclusive: RAM_Q==thr_q yields 0xFF.
- thr_q is held for the whole image; threshold changes mid-image have no effect.
- in_valid asserted outside IDLE is ignored.
- Latency from in_valid to first OUT_wen is 2 cycles. Total cycles = 2*HDR_SIZE + 4*(TOTAL_SIZE-HDR_SIZE)/3.

Decomposition:
- Shared definitions file holds BYTE_WIDTH, ADDR_WIDTH, BMP_HEADER_SIZE, BMP_TOTAL_SIZE and the state encodings; parameters default from these.
- Optional sub-module bin_threshold: combinational compare, 8-bit gray and threshold in, 0x00/0xFF out. It is reused by later adaptive-threshold work.

Test Plan:
- Bench parameters: HDR_SIZE=4, TOTAL_SIZE=13. Source RAM holds header bytes 0x42,0x4D,0x11,0x22, then gray pixels 0x10, 0x80, 0x7F (each tripled). Drive threshold=0x80 and pulse in_valid → output RAM = 42 4D 11 22 00 00 00 FF FF FF 00 00 00. bin_done rises after write to addr 12, and total active cycles = 20.
- Threshold boundary: pixels 0x00, 0xFF, 0x80 with threshold=0x00 → all FF. Same pixels with threshold=0xFF → 00, FF, 00.
- Change threshold and pulse in_valid mid-image → no restart, and output is unchanged versus the first run.
- Assert rst_n=0 during PIX_W1 → all outputs 0 at once, asynchronously. A fresh in_valid then reproduces the full image from address 0.
- Pulse in_valid after bin_done → no RAM_ren/OUT_wen activity, bin_done stays 1.
- TOTAL_SIZE=11 (partial final triple) → last write at addr 10, no write to addr 11 or 12, bin_done set.
